// File: rtl/vga_sync_rx_if.sv
// Sync inputs and recovered-timing outputs of vga_sync_rx, bundled as one interface.
interface vga_sync_rx_if;
  logic       i_hsync;
  logic       i_vsync;
  logic [9:0] o_hpos;
  logic [9:0] o_vpos;
  logic       o_display_on;
  logic       o_locked;
  logic       o_hsync_err;
  logic       o_vsync_err;
  logic [7:0] o_frame_count;

  modport master (
    output i_hsync, i_vsync,
    input  o_hpos, o_vpos, o_display_on, o_locked,
    input  o_hsync_err, o_vsync_err, o_frame_count
  );

  modport slave (
    input  i_hsync, i_vsync,
    output o_hpos, o_vpos, o_display_on, o_locked,
    output o_hsync_err, o_vsync_err, o_frame_count
  );
endinterface

// File: rtl/vga_sync_rx.sv
// Recovers pixel/line position from incoming VGA hsync/vsync, tracks lock and
// flags sync edges that arrive away from their expected position.
module vga_sync_rx #(
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL      = 800,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525,
  parameter int MAX_ERR      = 3
) (
  input  logic         i_clk25Mhz,
  input  logic         i_reset,
  vga_sync_rx_if.slave bus
);

  localparam int ERR_W = $clog2(MAX_ERR + 1);

  localparam logic [9:0] HACT_C  = 10'(H_ACTIVE);
  localparam logic [9:0] HSS_C   = 10'(H_SYNC_START);
  localparam logic [9:0] HLAST_C = 10'(H_TOTAL - 1);
  localparam logic [9:0] VACT_C  = 10'(V_ACTIVE);
  localparam logic [9:0] VSS_C   = 10'(V_SYNC_START);
  localparam logic [9:0] VLAST_C = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    HLOCK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [9:0]       hpos_q, hpos_d;
  logic [9:0]       vpos_q, vpos_d;
  logic [ERR_W-1:0] err_q, err_d, err_base;
  logic [ERR_W:0]   err_sum;
  logic [7:0]       frame_q, frame_d;
  logic             herr_q, verr_q, locked_q, disp_q, disp_d;
  logic             h_edge, v_edge, h_at_sync, h_err, v_err, v_load, h_wrap, err_full;

  always_comb begin
    h_edge    = hs_prev_q & ~hs_q;
    v_edge    = vs_prev_q & ~vs_q;
    h_at_sync = (hpos_q == HSS_C);
    // While tracking, an edge away from the sync column and a missing edge at it are both errors
    h_err     = (state_q != HUNT) && (h_edge != h_at_sync);
    v_err     = (state_q == LOCKED) && v_edge && (vpos_q != VSS_C);
    v_load    = v_edge && ((state_q == HLOCK) || v_err);
    h_wrap    = !h_edge && (hpos_q == HLAST_C);

    hpos_d = hpos_q + 10'd1;
    if (h_edge) begin
      hpos_d = HSS_C + 10'd1;
    end else if (h_wrap) begin
      hpos_d = '0;
    end

    vpos_d = vpos_q;
    if (v_load) begin
      vpos_d = VSS_C;
    end else if (h_wrap) begin
      vpos_d = (vpos_q == VLAST_C) ? '0 : vpos_q + 10'd1;
    end

    frame_d = frame_q;
    if ((state_q == LOCKED) && h_wrap && !v_load && (vpos_q == VLAST_C)) begin
      frame_d = frame_q + 8'd1;
    end

    err_base = (h_edge && h_at_sync) ? '0 : err_q;
    err_sum  = {1'b0, err_base} + {{ERR_W{1'b0}}, h_err} + {{ERR_W{1'b0}}, v_err};
    err_full = (err_sum >= (ERR_W + 1)'(MAX_ERR));

    state_d = state_q;
    case (state_q)
      HUNT:    if (h_edge) state_d = HLOCK;
      HLOCK:   if (err_full) state_d = HUNT;
               else if (v_edge) state_d = LOCKED;
      LOCKED:  if (err_full) state_d = HUNT;
      default: state_d = HUNT;
    endcase

    // Each new hunt starts with a clean error history
    err_d = err_full ? ERR_W'(MAX_ERR) : err_sum[ERR_W-1:0];
    if (state_d == HUNT) begin
      err_d = '0;
    end

    disp_d = (state_d == LOCKED) && (hpos_d < HACT_C) && (vpos_d < VACT_C);
  end

  always_ff @(posedge i_clk25Mhz) begin
    if (!i_reset) begin
      state_q   <= HUNT;
      hs_q      <= 1'b0;
      hs_prev_q <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hpos_q    <= '0;
      vpos_q    <= '0;
      err_q     <= '0;
      frame_q   <= '0;
      herr_q    <= 1'b0;
      verr_q    <= 1'b0;
      locked_q  <= 1'b0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_q      <= bus.i_hsync;
      hs_prev_q <= hs_q;
      vs_q      <= bus.i_vsync;
      vs_prev_q <= vs_q;
      hpos_q    <= hpos_d;
      vpos_q    <= vpos_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
      herr_q    <= h_err;
      verr_q    <= v_err;
      locked_q  <= (state_d == LOCKED);
      disp_q    <= disp_d;
    end
  end

  assign bus.o_hpos        = hpos_q;
  assign bus.o_vpos        = vpos_q;
  assign bus.o_display_on  = disp_q;
  assign bus.o_locked      = locked_q;
  assign bus.o_hsync_err   = herr_q;
  assign bus.o_vsync_err   = verr_q;
  assign bus.o_frame_count = frame_q;

endmodule
